// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: default widths and the
// completion record held in each pipe's slot.
package writeback_arbiter_pkg;

  localparam int NUM_PIPES      = 2;
  localparam int SEQ_NUM_BITS   = 5;
  localparam int NUM_PHYS_REGS  = 36;
  localparam int PHYS_ADDR_BITS = $clog2(NUM_PHYS_REGS);
  localparam int ARCH_ADDR_BITS = 5;
  localparam int DATA_BITS      = 32;

  typedef logic [SEQ_NUM_BITS-1:0] seq_num_t;

  typedef struct packed {
    seq_num_t                  seq_num;
    logic [PHYS_ADDR_BITS-1:0] preg;
    logic [ARCH_ADDR_BITS-1:0] waddr;
    logic [DATA_BITS-1:0]      wdata;
    logic                      wen;
  } wb_req_t;

endpackage

// File: rtl/wb_oldest_select.sv
// Combinational min-age reduction over N {val, age} pairs. Produces a one-hot
// grant; equal ages resolve to the lowest index.
module wb_oldest_select #(
  parameter int p_num      = 2,
  parameter int p_age_bits = 5
) (
  input  logic [p_num-1:0]      val,
  input  logic [p_age_bits-1:0] age [p_num],
  output logic [p_num-1:0]      grant,
  output logic                  grant_any
);

  logic [p_age_bits-1:0] best_age;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    grant     = '0;
    grant_any = 1'b0;
    best_age  = '1;
    for (int i = 0; i < p_num; i++) begin
      // Strict compare keeps the earlier (lower-index) winner on equal ages.
      if (val[i] && (!grant_any || (age[i] < best_age))) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_any = 1'b1;
        best_age  = age[i];
      end
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Arbitrates the single regfile write port / completion broadcast between the
// execute pipes: one holding slot per pipe, oldest-first grant, registered bus.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int p_num_pipes     = NUM_PIPES,
  parameter int p_seq_num_bits  = SEQ_NUM_BITS,
  parameter int p_num_phys_regs = NUM_PHYS_REGS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [p_num_pipes-1:0]             req_val,
  output logic [p_num_pipes-1:0]             req_rdy,
  input  logic [p_seq_num_bits-1:0]          req_seq_num [p_num_pipes],
  input  logic [$clog2(p_num_phys_regs)-1:0] req_preg    [p_num_pipes],
  input  logic [4:0]                         req_waddr   [p_num_pipes],
  input  logic [31:0]                        req_wdata   [p_num_pipes],
  input  logic [p_num_pipes-1:0]             req_wen,
  input  logic [p_seq_num_bits-1:0]          oldest_seq_num,
  input  logic                               squash_val,
  input  logic [p_seq_num_bits-1:0]          squash_seq_num,
  output logic                               cmp_val,
  output logic [p_seq_num_bits-1:0]          cmp_seq_num,
  output logic [$clog2(p_num_phys_regs)-1:0] cmp_preg,
  output logic [4:0]                         cmp_waddr,
  output logic [31:0]                        cmp_wdata,
  output logic                               cmp_wen
);

  wb_req_t                   slot_q     [p_num_pipes];
  logic [p_num_pipes-1:0]    slot_val_q;

  logic [p_seq_num_bits-1:0] slot_age   [p_num_pipes];
  logic [p_seq_num_bits-1:0] req_age    [p_num_pipes];
  logic [p_seq_num_bits-1:0] squash_age;
  logic [p_num_pipes-1:0]    slot_squashed;
  logic [p_num_pipes-1:0]    req_squashed;
  logic [p_num_pipes-1:0]    sel_val;
  logic [p_num_pipes-1:0]    grant;
  logic                      grant_any;
  logic [p_num_pipes-1:0]    accept;
  wb_req_t                   grant_req;

  // Ages are distances from the oldest in-flight inst, so modulo subtraction
  // handles the sequence-number wrap without special cases.
  assign squash_age = squash_seq_num - oldest_seq_num;

  always_comb begin
    for (int i = 0; i < p_num_pipes; i++) begin
      slot_age[i]      = slot_q[i].seq_num - oldest_seq_num;
      req_age[i]       = req_seq_num[i] - oldest_seq_num;
      slot_squashed[i] = squash_val && slot_val_q[i] && (slot_age[i] > squash_age);
      req_squashed[i]  = squash_val && (req_age[i] > squash_age);
    end
  end

  assign sel_val = slot_val_q & ~slot_squashed;
  assign req_rdy = ~slot_val_q | grant | slot_squashed;
  assign accept  = req_val & req_rdy;

  wb_oldest_select #(
    .p_num      (p_num_pipes),
    .p_age_bits (p_seq_num_bits)
  ) u_oldest_select (
    .val       (sel_val),
    .age       (slot_age),
    .grant     (grant),
    .grant_any (grant_any)
  );

  always_comb begin
    grant_req = '0;
    for (int i = 0; i < p_num_pipes; i++) begin
      if (grant[i]) grant_req = slot_q[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_val_q <= '0;
    end else begin
      for (int i = 0; i < p_num_pipes; i++) begin
        if (accept[i])                          slot_val_q[i] <= ~req_squashed[i];
        else if (grant[i] || slot_squashed[i])  slot_val_q[i] <= 1'b0;
      end
    end
  end

  // NOTE: slot payload has no reset; it is qualified by slot_val_q, and
  // leaving it unreset keeps the wide data flops plain enables.
  always_ff @(posedge clk) begin
    for (int i = 0; i < p_num_pipes; i++) begin
      if (accept[i]) begin
        slot_q[i] <= '{seq_num: req_seq_num[i], preg: req_preg[i],
                       waddr: req_waddr[i], wdata: req_wdata[i], wen: req_wen[i]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cmp_val <= 1'b0;
    else     cmp_val <= grant_any;
  end

  always_ff @(posedge clk) begin
    if (grant_any) begin
      cmp_seq_num <= grant_req.seq_num;
      cmp_preg    <= grant_req.preg;
      cmp_waddr   <= grant_req.waddr;
      cmp_wdata   <= grant_req.wdata;
      cmp_wen     <= grant_req.wen;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed vector table, corner
// sequences and randomized traffic against an age-ordered reference model.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_val;
  logic [1:0]  req_rdy;
  logic [4:0]  req_seq_num [2];
  logic [5:0]  req_preg    [2];
  logic [4:0]  req_waddr   [2];
  logic [31:0] req_wdata   [2];
  logic [1:0]  req_wen;
  logic [4:0]  oldest_seq_num;
  logic        squash_val;
  logic [4:0]  squash_seq_num;
  logic        cmp_val;
  logic [4:0]  cmp_seq_num;
  logic [5:0]  cmp_preg;
  logic [4:0]  cmp_waddr;
  logic [31:0] cmp_wdata;
  logic        cmp_wen;

  writeback_arbiter dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy), .req_seq_num(req_seq_num),
    .req_preg(req_preg), .req_waddr(req_waddr), .req_wdata(req_wdata),
    .req_wen(req_wen), .oldest_seq_num(oldest_seq_num),
    .squash_val(squash_val), .squash_seq_num(squash_seq_num),
    .cmp_val(cmp_val), .cmp_seq_num(cmp_seq_num), .cmp_preg(cmp_preg),
    .cmp_waddr(cmp_waddr), .cmp_wdata(cmp_wdata), .cmp_wen(cmp_wen)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: per-pipe pending completions plus the expected bus word.
  bit        m_val [2];
  wb_req_t   m_req [2];
  bit        e_val;
  wb_req_t   e_cmp;
  logic [1:0] m_rdy;
  logic [1:0] obs_rdy;

  function automatic int age_of(input logic [4:0] s);
    logic [4:0] d;
    d = s - oldest_seq_num;
    return int'(d);
  endfunction

  task automatic set_req(input int i, input logic v, input logic [4:0] seq,
                         input logic [5:0] preg, input logic [4:0] waddr,
                         input logic [31:0] wdata, input logic wen);
    req_val[i] = v;       req_seq_num[i] = seq; req_preg[i] = preg;
    req_waddr[i] = waddr; req_wdata[i] = wdata; req_wen[i] = wen;
  endtask

  task automatic set_auto(input int i, input logic v, input logic [4:0] seq);
    set_req(i, v, seq, {1'b0, seq} + 6'd3, seq ^ 5'h1f, 32'hA500_0000 | 32'(seq), seq[0]);
  endtask

  task automatic idle();
    set_auto(0, 1'b0, 5'd0);
    set_auto(1, 1'b0, 5'd0);
    squash_val = 1'b0;
  endtask

  // One clock: check rdy mid-cycle against the model, advance the model, then
  // check the registered bus just after the edge.
  task automatic tick();
    int  sq_age, best, best_age;
    int  age [2];
    bit  kill [2];
    @(negedge clk);
    obs_rdy = req_rdy;
    sq_age = age_of(squash_seq_num);
    best = -1;
    best_age = 0;
    for (int i = 0; i < 2; i++) begin
      age[i]  = age_of(m_req[i].seq_num);
      kill[i] = squash_val && m_val[i] && (age[i] > sq_age);
      if (m_val[i] && !kill[i] && (best < 0 || age[i] < best_age)) begin
        best = i;
        best_age = age[i];
      end
    end
    for (int i = 0; i < 2; i++) m_rdy[i] = !m_val[i] || (best == i) || kill[i];
    check("req_rdy", 64'(obs_rdy), 64'(m_rdy));
    e_val = (best >= 0);
    if (best >= 0) e_cmp = m_req[best];
    for (int i = 0; i < 2; i++) begin
      if (req_val[i] && m_rdy[i]) begin
        m_val[i] = !(squash_val && (age_of(req_seq_num[i]) > sq_age));
        m_req[i] = '{seq_num: req_seq_num[i], preg: req_preg[i],
                     waddr: req_waddr[i], wdata: req_wdata[i], wen: req_wen[i]};
      end else if (best == i || kill[i]) begin
        m_val[i] = 1'b0;
      end
    end
    if (rst) begin
      m_val[0] = 1'b0; m_val[1] = 1'b0; e_val = 1'b0;
    end
    @(posedge clk);
    #1;
    if (e_val)
      check("cmp_bus", 64'({cmp_val, cmp_seq_num, cmp_preg, cmp_waddr, cmp_wdata, cmp_wen}),
            64'({1'b1, e_cmp}));
    else
      check("cmp_val_idle", 64'(cmp_val), 64'd0);
  endtask

  typedef struct {
    logic [1:0] val;
    logic [4:0] s0, s1, old;
    logic       sqv;
    logic [4:0] sqs;
    logic [1:0] rdy;
    logic       cv;
    logic [4:0] cs;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] val, input logic [4:0] s0, input logic [4:0] s1,
                              input logic [4:0] old, input logic sqv, input logic [4:0] sqs,
                              input logic [1:0] rdy, input logic cv, input logic [4:0] cs);
    vec_t v;
    v.val = val; v.s0 = s0; v.s1 = s1; v.old = old; v.sqv = sqv; v.sqs = sqs;
    v.rdy = rdy; v.cv = cv; v.cs = cs;
    return v;
  endfunction

  vec_t vecs [$];

  bit         pend_val [2];
  logic [4:0] pend_seq [2];
  logic [31:0] pend_data [2];
  logic [4:0] next_seq;

  initial begin
    // Contention at oldest 0.
    vecs.push_back(mk(2'b11,  5, 2,  0, 0, 0, 2'b11, 0,  0));
    vecs.push_back(mk(2'b00,  0, 0,  0, 0, 0, 2'b10, 1,  2));
    vecs.push_back(mk(2'b00,  0, 0,  0, 0, 0, 2'b11, 1,  5));
    vecs.push_back(mk(2'b00,  0, 0,  0, 0, 0, 2'b11, 0,  0));
    // Wrap: oldest 30, seq 31 is older than seq 1.
    vecs.push_back(mk(2'b11,  1, 31, 30, 0, 0, 2'b11, 0,  0));
    vecs.push_back(mk(2'b00,  0, 0, 30, 0, 0, 2'b10, 1, 31));
    vecs.push_back(mk(2'b00,  0, 0, 30, 0, 0, 2'b11, 1,  1));
    vecs.push_back(mk(2'b00,  0, 0, 30, 0, 0, 2'b11, 0,  0));
    // Squash at 4 kills held seq 6, keeps seq 4.
    vecs.push_back(mk(2'b11,  4, 6,  0, 0, 0, 2'b11, 0,  0));
    vecs.push_back(mk(2'b00,  0, 0,  0, 1, 4, 2'b11, 1,  4));
    vecs.push_back(mk(2'b00,  0, 0,  0, 0, 0, 2'b11, 0,  0));
    vecs.push_back(mk(2'b00,  0, 0,  0, 0, 0, 2'b11, 0,  0));
    // Squashed incoming request is accepted and dropped.
    vecs.push_back(mk(2'b01,  9, 0,  0, 1, 3, 2'b11, 0,  0));
    vecs.push_back(mk(2'b00,  0, 0,  0, 0, 0, 2'b11, 0,  0));

    m_val[0] = 1'b0; m_val[1] = 1'b0;
    idle();
    oldest_seq_num = 5'd0;
    squash_seq_num = 5'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_cmp_val", 64'(cmp_val), 64'd0);
    check("reset_req_rdy", 64'(req_rdy), 64'h3);

    // Test 1: single completion on pipe 0.
    set_req(0, 1'b1, 5'd3, 6'd7, 5'd9, 32'hDEAD, 1'b1);
    tick();
    idle();
    tick();
    check("t1_bus", 64'({cmp_val, cmp_seq_num, cmp_preg, cmp_wdata, cmp_wen}),
          64'({1'b1, 5'd3, 6'd7, 32'hDEAD, 1'b1}));
    tick();
    check("t1_drain", 64'(cmp_val), 64'd0);

    // Table-driven directed vectors.
    foreach (vecs[k]) begin
      set_auto(0, vecs[k].val[0], vecs[k].s0);
      set_auto(1, vecs[k].val[1], vecs[k].s1);
      oldest_seq_num = vecs[k].old;
      squash_val     = vecs[k].sqv;
      squash_seq_num = vecs[k].sqs;
      tick();
      check($sformatf("vec%0d_rdy", k), 64'(obs_rdy), 64'(vecs[k].rdy));
      if (vecs[k].cv)
        check($sformatf("vec%0d_cmp", k), 64'({cmp_val, cmp_seq_num}), 64'({1'b1, vecs[k].cs}));
      else
        check($sformatf("vec%0d_cmp_val", k), 64'(cmp_val), 64'd0);
    end

    // Test 5: streaming on pipe 0.
    idle();
    oldest_seq_num = 5'd0;
    for (int k = 0; k < 8; k++) begin
      set_auto(0, 1'b1, 5'(k));
      tick();
      check($sformatf("stream_rdy%0d", k), 64'(obs_rdy[0]), 64'd1);
      if (k > 0)
        check($sformatf("stream_cmp%0d", k), 64'({cmp_val, cmp_seq_num}), 64'({1'b1, 5'(k - 1)}));
    end
    idle();
    tick();
    check("stream_last", 64'({cmp_val, cmp_seq_num}), 64'({1'b1, 5'd7}));
    tick();
    check("stream_end", 64'(cmp_val), 64'd0);

    // Test 6: reset with both slots full.
    set_auto(0, 1'b1, 5'd10);
    set_auto(1, 1'b1, 5'd11);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_cmp_val", 64'(cmp_val), 64'd0);
    tick();
    check("rst_rdy", 64'(obs_rdy), 64'h3);
    check("rst_no_stale", 64'(cmp_val), 64'd0);
    tick();
    check("rst_no_stale2", 64'(cmp_val), 64'd0);

    // Randomized traffic with unique, advancing sequence numbers.
    next_seq = 5'd0;
    pend_val[0] = 1'b0; pend_val[1] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend_val[i] && ($urandom_range(0, 2) != 0)) begin
          pend_val[i]  = 1'b1;
          pend_seq[i]  = next_seq;
          pend_data[i] = $urandom;
          next_seq     = next_seq + 5'd1;
        end
        set_req(i, pend_val[i], pend_seq[i], 6'($urandom_range(0, 35)),
                5'($urandom), pend_data[i], 1'($urandom));
      end
      oldest_seq_num = next_seq - 5'd12;
      squash_val     = ($urandom_range(0, 9) == 0);
      squash_seq_num = next_seq - 5'($urandom_range(1, 8));
      tick();
      for (int i = 0; i < 2; i++) if (pend_val[i] && m_rdy[i]) pend_val[i] = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
